// File: rtl/regfile_sb.sv
// Multi-ported register file with a byte-enabled and a full-word write port,
// optional same-cycle write forwarding, and a per-register pending scoreboard.
module regfile_sb #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NRD     = 2,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic [DW-1:0]     wr0_data,
  input  logic [DW/8-1:0]   wr0_be,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic [DW-1:0]     wr1_data,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [AW:0]       busy_cnt,
  output logic              wr_collide
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned NB    = DW / 8;

  logic [DW-1:0]    mem_q [Depth];
  logic [Depth-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_d;
  logic [DW-1:0]    wr0_word;
  logic             wr0_ok, wr1_ok;
  logic [AW-1:0]    ra;
  logic [DW-1:0]    rv;

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old_w, logic [DW-1:0] new_w,
                                          logic [NB-1:0] be);
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    wr0_word = merge(mem_q[wr0_addr], wr0_data, wr0_be);
    wr0_ok   = wr0_en && !(ZERO_R0 && (wr0_addr == '0));
    wr1_ok   = wr1_en && !(ZERO_R0 && (wr1_addr == '0));
  end

  // wr1 is applied after wr0 so it owns every byte on a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (wr0_ok) mem_q[wr0_addr] <= wr0_word;
      if (wr1_ok) mem_q[wr1_addr] <= wr1_data;
    end
  end

  // Writes clear pending, reservation applied last so it wins on a shared address.
  always_comb begin
    busy_d = busy_q;
    if (wr0_en) busy_d[wr0_addr] = 1'b0;
    if (wr1_en) busy_d[wr1_addr] = 1'b0;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (ZERO_R0) busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < Depth; i++) cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      busy_cnt   <= '0;
      wr_collide <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt   <= cnt_d;
      wr_collide <= wr0_en && wr1_en && (wr0_addr == wr1_addr);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rv      = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      rv = mem_q[ra];
      if (BYPASS) begin
        if (wr0_en && (wr0_addr == ra)) rv = merge(rv, wr0_data, wr0_be);
        if (wr1_en && (wr1_addr == ra)) rv = wr1_data;
      end
      // Forwarded data must not leak out during reset or for the hard-wired zero.
      if (!rst || (ZERO_R0 && (ra == '0))) rv = '0;
      rd_data[k*DW +: DW] = rv;
      rd_busy[k]          = busy_q[ra] && rst;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed table, randomized ops against an array model,
// and an asynchronous mid-cycle reset sequence. Runs a bypass and a non-bypass instance.
module tb_regfile_sb;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned NRD = 2;
  localparam int unsigned N   = 2 ** AW;

  logic              clk, rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]    rd_busy, rd_busy_nb;
  logic              wr0_en, wr1_en, rsv_en;
  logic [AW-1:0]     wr0_addr, wr1_addr, rsv_addr;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic [DW/8-1:0]   wr0_be;
  logic [AW:0]       busy_cnt, busy_cnt_nb;
  logic              wr_collide, wr_collide_nb;

  regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_be(wr0_be),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt), .wr_collide(wr_collide)
  );

  regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_be(wr0_be),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_nb), .wr_collide(wr_collide_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_fail;

  // Reference state: architectural register contents, pending set, registered flags.
  logic [DW-1:0] m_mem [N];
  bit            m_busy [N];
  int            m_cnt;
  bit            m_coll;

  typedef struct {
    bit w0e; logic [AW-1:0] w0a; logic [DW-1:0] w0d; logic [3:0] w0b;
    bit w1e; logic [AW-1:0] w1a; logic [DW-1:0] w1d;
    bit rse; logic [AW-1:0] rsa;
    logic [AW-1:0] ra;
    logic [DW-1:0] e_rd; logic [DW-1:0] e_rd_nb; bit e_busy; int e_cnt; bit e_coll;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt  = 0;
    m_coll = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_read(input bit byp, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!rst || a == 0) return '0;
    v = m_mem[a];
    if (byp && wr0_en && wr0_addr == a)
      for (int b = 0; b < DW / 8; b++) if (wr0_be[b]) v[b*8 +: 8] = wr0_data[b*8 +: 8];
    if (byp && wr1_en && wr1_addr == a) v = wr1_data;
    return v;
  endfunction

  task automatic model_update();
    for (int b = 0; b < DW / 8; b++)
      if (wr0_en && wr0_be[b]) m_mem[wr0_addr][b*8 +: 8] = wr0_data[b*8 +: 8];
    if (wr1_en) m_mem[wr1_addr] = wr1_data;
    m_mem[0] = '0;
    if (wr0_en) m_busy[wr0_addr] = 1'b0;
    if (wr1_en) m_busy[wr1_addr] = 1'b0;
    if (rsv_en) m_busy[rsv_addr] = 1'b1;
    m_busy[0] = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < N; i++) m_cnt += int'(m_busy[i]);
    m_coll = wr0_en && wr1_en && (wr0_addr == wr1_addr);
  endtask

  task automatic check_model();
    logic [AW-1:0] a;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*AW +: AW];
      chk("rd_data_byp", rd_data[k*DW +: DW], exp_read(1'b1, a));
      chk("rd_data_nobyp", rd_data_nb[k*DW +: DW], exp_read(1'b0, a));
      chk("rd_busy", rd_busy[k], m_busy[a]);
      chk("rd_busy_nb", rd_busy_nb[k], m_busy[a]);
    end
    chk("busy_cnt", busy_cnt, m_cnt);
    chk("busy_cnt_nb", busy_cnt_nb, m_cnt);
    chk("wr_collide", wr_collide, m_coll);
  endtask

  task automatic idle_inputs();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0; wr0_be = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    rsv_en = 0; rsv_addr = '0; rd_addr = '0;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, N - 1))
                                       : AW'($urandom_range(0, 5));
  endfunction

  initial begin
    n_vec = 0;
    n_fail = 0;
    model_reset();
    idle_inputs();
    rst = 1'b0;
    #12;
    chk("reset_busy_cnt", busy_cnt, 0);
    chk("reset_collide", wr_collide, 0);
    chk("reset_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_update();
    #1;

    //           w0e w0a  w0d           w0b  w1e w1a w1d           rse rsa ra  e_rd          e_rd_nb     bsy cnt col
    tbl[0]  = '{0, 0, 32'h0,        4'h0, 1, 5, 32'h11223344, 0, 0, 5, 32'h11223344, 32'h0,        0, 0, 0};
    tbl[1]  = '{1, 5, 32'hAABBCCDD, 4'h5, 0, 0, 32'h0,        0, 0, 5, 32'h11BB33DD, 32'h11223344, 0, 0, 0};
    tbl[2]  = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        0, 0, 5, 32'h11BB33DD, 32'h11BB33DD, 0, 0, 0};
    tbl[3]  = '{1, 7, 32'h1,        4'hF, 1, 7, 32'h2,        0, 0, 7, 32'h2,        32'h0,        0, 0, 0};
    tbl[4]  = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        0, 0, 7, 32'h2,        32'h2,        0, 0, 1};
    tbl[5]  = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        0, 0, 7, 32'h2,        32'h2,        0, 0, 0};
    tbl[6]  = '{0, 0, 32'h0,        4'h0, 1, 3, 32'hDEAD,     0, 0, 3, 32'hDEAD,     32'h0,        0, 0, 0};
    tbl[7]  = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        0, 0, 3, 32'hDEAD,     32'hDEAD,     0, 0, 0};
    tbl[8]  = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        1, 4, 4, 32'h0,        32'h0,        0, 0, 0};
    tbl[9]  = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        0, 0, 4, 32'h0,        32'h0,        1, 1, 0};
    tbl[10] = '{1, 4, 32'h55,       4'h1, 0, 0, 32'h0,        1, 4, 4, 32'h55,       32'h0,        1, 1, 0};
    tbl[11] = '{0, 0, 32'h0,        4'h0, 1, 4, 32'h66,       0, 0, 4, 32'h66,       32'h55,       1, 1, 0};
    tbl[12] = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        0, 0, 4, 32'h66,       32'h66,       0, 0, 0};
    tbl[13] = '{1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h0,        1, 0, 0, 32'h0,        32'h0,        0, 0, 0};
    tbl[14] = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      wr0_en = tbl[i].w0e; wr0_addr = tbl[i].w0a; wr0_data = tbl[i].w0d; wr0_be = tbl[i].w0b;
      wr1_en = tbl[i].w1e; wr1_addr = tbl[i].w1a; wr1_data = tbl[i].w1d;
      rsv_en = tbl[i].rse; rsv_addr = tbl[i].rsa;
      rd_addr = {tbl[i].ra, tbl[i].ra};
      @(negedge clk);
      chk($sformatf("tbl%0d_rd", i), rd_data[DW-1:0], tbl[i].e_rd);
      chk($sformatf("tbl%0d_rd_nb", i), rd_data_nb[DW-1:0], tbl[i].e_rd_nb);
      chk($sformatf("tbl%0d_busy", i), rd_busy[0], tbl[i].e_busy);
      chk($sformatf("tbl%0d_cnt", i), busy_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_coll", i), wr_collide, tbl[i].e_coll);
      check_model();
      @(posedge clk);
      model_update();
      #1;
    end

    for (int i = 0; i < 400; i++) begin
      wr0_en   = ($urandom_range(0, 1) == 1);
      wr0_addr = rnd_addr();
      wr0_data = $urandom;
      wr0_be   = 4'($urandom);
      wr1_en   = ($urandom_range(0, 2) == 0);
      wr1_addr = rnd_addr();
      wr1_data = $urandom;
      rsv_en   = ($urandom_range(0, 1) == 1);
      rsv_addr = rnd_addr();
      rd_addr  = {rnd_addr(), rnd_addr()};
      run_cycle();
    end

    // Drain pending bits, then reserve exactly ten registers with data behind them.
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      wr1_en = 1; wr1_addr = AW'(i); wr1_data = $urandom;
      run_cycle();
    end
    for (int i = 1; i <= 10; i++) begin
      idle_inputs();
      rsv_en = 1; rsv_addr = AW'(i);
      wr1_en = 1; wr1_addr = AW'(i + 10); wr1_data = 32'hC0DE0000 + i;
      rd_addr = {AW'(i + 10), AW'(i)};
      run_cycle();
    end
    idle_inputs();
    rd_addr = {AW'(12), AW'(3)};
    run_cycle();
    chk("pre_reset_cnt", busy_cnt, 10);

    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h12345678; wr0_be = 4'hF;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'hFACEFACE;
    rsv_en = 1; rsv_addr = 20;
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_busy_cnt", busy_cnt, 0);
    chk("rst_collide", wr_collide, 0);
    for (int a = 0; a < N; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      #0.5;
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_data_nb", rd_data_nb, 0);
      chk("rst_rd_busy", rd_busy, 0);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_update();
    #1;
    for (int a = 0; a < 16; a++) begin
      rd_addr = {AW'(a + 8), AW'(a)};
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DW, default 32, meaning register data width, a multiple of 8.
REQ-002 SHALL have parameter AW, default 5, meaning address width; depth is 2**AW.
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports.
REQ-004 SHALL have parameter ZERO_R0, default 1, meaning register 0 reads zero and ignores writes and reservations.
REQ-005 SHALL have parameter BYPASS, default 1, meaning same-cycle write data is forwarded to read ports.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port rd_addr, input, NRD*AW, meaning read addresses; port k is slice [k*AW +: AW].
REQ-009 SHALL have port rd_data, output, NRD*DW, meaning combinational read data per port.
REQ-010 SHALL have port rd_busy, output, NRD, meaning scoreboard pending bit of each read address.
REQ-011 SHALL have ports wr0_en (1), wr0_addr (AW), wr0_data (DW) and wr0_be (DW/8), all inputs, meaning primary write port with byte enables.
REQ-012 SHALL have ports wr1_en (1), wr1_addr (AW) and wr1_data (DW), all inputs, meaning secondary full-word write port.
REQ-013 SHALL have ports rsv_en (1) and rsv_addr (AW), both inputs, meaning mark a destination register pending.
REQ-014 SHALL have port busy_cnt, output, AW+1, meaning registered count of pending registers.
REQ-015 SHALL have port wr_collide, output, 1, meaning registered one-cycle flag for a same-address dual write.

Function
REQ-016 SHALL, on wr0_en, update only the bytes of wr0_addr whose wr0_be bit is 1.
REQ-017 SHALL, on wr1_en, replace the full word at wr1_addr.
REQ-018 SHALL, when both write ports are enabled to the same address, apply wr0 bytes first and wr1 last, so wr1 wins every byte, and assert wr_collide in the following cycle only.
REQ-019 SHALL keep the storage and busy bit of register 0 at zero when ZERO_R0=1, with rd_data zero and rd_busy 0 for address 0.
REQ-020 SHALL, with BYPASS=1, return the post-write value (wr1 over masked wr0 over stored) for a read address matching an active write in the same cycle.
REQ-021 SHALL, with BYPASS=0, return the stored value only, with the new value visible the cycle after the write.
REQ-022 SHALL set busy[rsv_addr] on rsv_en and clear busy[a] on any write enable to address a.
REQ-023 SHALL let the set win when a reservation and a write hit the same address in one cycle.
REQ-024 SHALL leave a register already busy still busy when reserved again, without double counting.
REQ-025 SHALL drive rd_busy combinationally from the current busy bits, with no bypass of same-cycle set or clear.
REQ-026 SHALL update busy_cnt each cycle to the population count of the next-state busy vector, ranging 0 to 2**AW.
REQ-027 SHALL make writes to a non-busy register legal, with no error flag.

Reset
REQ-028 SHALL, while rst=0, asynchronously clear all registers, all busy bits, busy_cnt and wr_collide to 0.
REQ-029 SHALL drive rd_data to 0 for every address and rd_busy to 0 while in reset.
REQ-030 SHALL discard any operation in flight when reset asserts mid-cycle, with the first post-reset edge behaving as from power-up.

Verification
REQ-031 Byte-enable write: r5=0x11223344, wr0 addr 5, data 0xAABBCCDD, be=0b0101 -> next cycle r5=0x11BB33DD.
REQ-032 Dual-write collision: wr0 addr 7 data 0x1 be=0xF with wr1 addr 7 data 0x2 -> r7=0x2, wr_collide=1 for exactly one cycle.
REQ-033 Bypass: BYPASS=1, wr1 addr 3 data 0xDEAD with rd_addr port0=3 same cycle -> rd_data port0=0xDEAD; with BYPASS=0 -> old value, then 0xDEAD next cycle.
REQ-034 Scoreboard: rsv 4 -> rd_busy=1 and busy_cnt=1; rsv 4 and wr0 4 together -> stays busy, busy_cnt=1; wr1 4 alone -> busy 0, busy_cnt=0.
REQ-035 Zero register: ZERO_R0=1, wr0 addr 0 data 0xFFFFFFFF be=0xF and rsv 0 -> rd_data 0, rd_busy 0, busy_cnt 0.
REQ-036 Reset mid-operation: reserve 10 registers, write data, pull rst low between edges -> all reads 0, busy_cnt 0 immediately.
